// File: rtl/riscv_defs_pkg.sv
// Shared RV32I multicycle definitions: state codes, opcodes, datapath select encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_defs;

  // FSM state codes (4-bit)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECR    = S_EXECR,
    EXECI    = S_EXECI,
    ALUWB    = S_ALUWB,
    BEQ      = S_BEQ,
    JAL      = S_JAL
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // alu_op: ALU decoder interprets funct fields only for ALUOP_FUNCT
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // One-hot instruction class
  typedef struct packed {
    logic load;
    logic store;
    logic rtype;
    logic itype;
    logic branch;
    logic jal;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Opcode classifier: one-hot instruction class plus immediate format select.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode (in, 7) -> cls (one-hot class), imm_src (2).
module instr_class_decode
  import riscv_defs::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic [1:0]   imm_src
);

  always_comb begin
    cls     = '0;
    imm_src = IMM_I;
    unique case (opcode)
      OP_LOAD:   begin cls.load   = 1'b1; imm_src = IMM_I; end
      OP_STORE:  begin cls.store  = 1'b1; imm_src = IMM_S; end
      OP_RTYPE:  begin cls.rtype  = 1'b1; end
      OP_ITYPE:  begin cls.itype  = 1'b1; imm_src = IMM_I; end
      OP_BRANCH: begin cls.branch = 1'b1; imm_src = IMM_B; end
      OP_JAL:    begin cls.jal    = 1'b1; imm_src = IMM_J; end
      default:   begin cls.illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main controller: FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: FETCH-to-FETCH lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles.
// Backpressure: mem_ready=0 stalls FETCH, MEMREAD and MEMWRITE with outputs held.
// Ports: clk, rst_n, opcode[6:0], zero, mem_ready in; write enables, datapath selects,
//        imm_src and sticky illegal_op out.
module multicycle_controller
  import riscv_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  state_t       state, state_nxt;
  instr_class_t cls;
  logic         pc_update, branch;
  logic         mem_write_raw, ir_write_raw, reg_write_raw;

  instr_class_decode u_decode (
    .opcode  (opcode),
    .cls     (cls),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Sticky: set on the edge leaving a DECODE of an unsupported opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           illegal_op <= 1'b0;
    else if (state == DECODE && cls.illegal) illegal_op <= 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    unique case (state)
      FETCH: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        // Computes branch/jump target PC+imm ahead of need.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (cls.load || cls.store) state_nxt = MEMADR;
        else if (cls.rtype)        state_nxt = EXECR;
        else if (cls.itype)        state_nxt = EXECI;
        else if (cls.branch)       state_nxt = BEQ;
        else if (cls.jal)          state_nxt = JAL;
        else                       state_nxt = FETCH;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_nxt = cls.store ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_nxt     = FETCH;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_nxt = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        state_nxt     = FETCH;
      end
      JAL: begin
        // ALU forms old PC + 4 for rd while the target from DECODE loads the PC.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is held,
  // even though FETCH would otherwise follow mem_ready.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign mem_write = rst_n & mem_write_raw;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output bundles hand-written from the state table.
// Latency: n/a.
// Backpressure: mem_ready stalls exercised in FETCH, MEMREAD and MEMWRITE.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal_op;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Bundle: {pc_write, adr_src, mem_write, ir_write, reg_write,
  //          result_src, alu_src_a, alu_src_b, alu_op}
  localparam logic [12:0] E_FETCH   = 13'b1_0_0_1_0_10_00_10_00;
  localparam logic [12:0] E_FSTALL  = 13'b0_0_0_0_0_10_00_10_00;
  localparam logic [12:0] E_DECODE  = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] E_MEMADR  = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] E_MEMREAD = 13'b0_1_0_0_0_00_00_00_00;
  localparam logic [12:0] E_MEMWB   = 13'b0_0_0_0_1_01_00_00_00;
  localparam logic [12:0] E_MEMWR   = 13'b0_1_1_0_0_00_00_00_00;
  localparam logic [12:0] E_EXECR   = 13'b0_0_0_0_0_00_10_00_10;
  localparam logic [12:0] E_EXECI   = 13'b0_0_0_0_0_00_10_01_10;
  localparam logic [12:0] E_ALUWB   = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] E_JAL     = 13'b1_0_0_0_0_00_01_10_00;
  localparam logic [12:0] E_BEQ_T   = 13'b1_0_0_0_0_00_10_00_01;
  localparam logic [12:0] E_BEQ_N   = 13'b0_0_0_0_0_00_10_00_01;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] bundle();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op};
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic [6:0] op, input logic mr, input logic z,
                     input logic [12:0] exp, input logic [1:0] imm, input logic ill);
    opcode = op; mem_ready = mr; zero = z;
    #1;
    check({tag, ".out"}, 32'(bundle()), 32'(exp));
    check({tag, ".imm"}, 32'(imm_src), 32'(imm));
    check({tag, ".ill"}, 32'(illegal_op), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = LW; zero = 1'b0; mem_ready = 1'b1;
    #1;
    // Reset: FETCH selects but enables gated off even with mem_ready=1.
    check("rst.out", 32'(bundle()), 32'(E_FSTALL));
    check("rst.ill", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw, no stalls: 5 cycles, reg_write only in MEMWB
    cyc("lw.f",  LW, 1, 0, E_FETCH,   2'b00, 0);
    cyc("lw.d",  LW, 1, 1, E_DECODE,  2'b00, 0);
    cyc("lw.ma", LW, 1, 1, E_MEMADR,  2'b00, 0);
    cyc("lw.mr", LW, 1, 0, E_MEMREAD, 2'b00, 0);
    cyc("lw.wb", LW, 1, 0, E_MEMWB,   2'b00, 0);

    // sw with 3 stall cycles in MEMWRITE: 7 cycles total
    cyc("sw.f",  SW, 1, 0, E_FETCH,  2'b01, 0);
    cyc("sw.d",  SW, 1, 0, E_DECODE, 2'b01, 0);
    cyc("sw.ma", SW, 1, 0, E_MEMADR, 2'b01, 0);
    cyc("sw.w0", SW, 0, 1, E_MEMWR,  2'b01, 0);
    cyc("sw.w1", SW, 0, 0, E_MEMWR,  2'b01, 0);
    cyc("sw.w2", SW, 0, 0, E_MEMWR,  2'b01, 0);
    cyc("sw.w3", SW, 1, 0, E_MEMWR,  2'b01, 0);

    // beq taken then not taken, 3 cycles each
    cyc("beq1.f", BQ, 1, 1, E_FETCH,  2'b10, 0);
    cyc("beq1.d", BQ, 1, 1, E_DECODE, 2'b10, 0);
    cyc("beq1.b", BQ, 1, 1, E_BEQ_T,  2'b10, 0);
    cyc("beq0.f", BQ, 1, 0, E_FETCH,  2'b10, 0);
    cyc("beq0.d", BQ, 1, 0, E_DECODE, 2'b10, 0);
    cyc("beq0.b", BQ, 1, 0, E_BEQ_N,  2'b10, 0);

    // jal
    cyc("jal.f",  JL, 1, 0, E_FETCH,  2'b11, 0);
    cyc("jal.d",  JL, 1, 0, E_DECODE, 2'b11, 0);
    cyc("jal.j",  JL, 1, 0, E_JAL,    2'b11, 0);
    cyc("jal.wb", JL, 1, 1, E_ALUWB,  2'b11, 0);

    // R-type
    cyc("r.f",  RT, 1, 0, E_FETCH,  2'b00, 0);
    cyc("r.d",  RT, 1, 0, E_DECODE, 2'b00, 0);
    cyc("r.x",  RT, 1, 1, E_EXECR,  2'b00, 0);
    cyc("r.wb", RT, 1, 0, E_ALUWB,  2'b00, 0);

    // I-type with one FETCH stall
    cyc("i.fs", IT, 0, 0, E_FSTALL, 2'b00, 0);
    cyc("i.f",  IT, 1, 0, E_FETCH,  2'b00, 0);
    cyc("i.d",  IT, 1, 0, E_DECODE, 2'b00, 0);
    cyc("i.x",  IT, 1, 0, E_EXECI,  2'b00, 0);
    cyc("i.wb", IT, 1, 0, E_ALUWB,  2'b00, 0);

    // illegal opcode: DECODE -> FETCH, flag visible after the DECODE edge
    cyc("ill.f", BAD, 1, 0, E_FETCH,  2'b00, 0);
    cyc("ill.d", BAD, 1, 1, E_DECODE, 2'b00, 0);

    // lw (flag still sticky), stalled in MEMREAD, then reset mid-cycle
    cyc("lw2.f",  LW, 1, 0, E_FETCH,   2'b00, 1);
    cyc("lw2.d",  LW, 1, 0, E_DECODE,  2'b00, 1);
    cyc("lw2.ma", LW, 1, 0, E_MEMADR,  2'b00, 1);
    cyc("lw2.mr", LW, 0, 0, E_MEMREAD, 2'b00, 1);
    opcode = LW; mem_ready = 1'b1; zero = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out", 32'(bundle()), 32'(E_FSTALL));
    check("arst.ill", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
    check("arst.hold", 32'(bundle()), 32'(E_FSTALL));
    check("arst.rw",   32'(reg_write), 32'd0);
    rst_n = 1'b1;

    // clean restart: full lw from FETCH
    cyc("lw3.f",  LW, 1, 0, E_FETCH,   2'b00, 0);
    cyc("lw3.d",  LW, 1, 0, E_DECODE,  2'b00, 0);
    cyc("lw3.ma", LW, 1, 0, E_MEMADR,  2'b00, 0);
    cyc("lw3.mr", LW, 1, 0, E_MEMREAD, 2'b00, 0);
    cyc("lw3.wb", LW, 1, 0, E_MEMWB,   2'b00, 0);
    cyc("lw3.f2", LW, 0, 0, E_FSTALL,  2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
